control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle controller that sequences the 16-bit processor datapath: instruction ROM, register file, ALU, data memory and the RF write-source mux.
- Owns the program counter, the instruction register and the control FSM.
- Drives every datapath select, enable and address from the current state and IR fields.
- Sits at the top of the processor, beside the datapath. PC, IR and state are exported so the processor top can bring them out for the bench monitor.

Parameters:
- PC_W, 5, program counter / instruction ROM address width
- IW, 16, instruction width
- DA_W, 8, data memory address width
- RA_W, 4, register file address width

Ports:
- Clk  input  1  system clock; all state changes on its rising edge
- Reset  input  1  asynchronous, active-high; forces Init, PC=0, IR=0
- Instr_in  input  IW  instruction ROM data; combinational read of PC_addr
- PC_addr  output  PC_W  current PC, to ROM address
- IR_out  output  IW  current instruction register
- State  output  4  current FSM state code
- D_addr  output  DA_W  data memory address
- D_wr  output  1  data memory write enable
- RF_s  output  1  RF write-source select: 1 = data memory, 0 = ALU
- RF_W_addr  output  RA_W  RF write address
- RF_W_en  output  1  RF write enable
- RF_Ra_addr  output  RA_W  RF read port A address
- RF_Rb_addr  output  RA_W  RF read port B address
- ALU_s0  output  3  ALU op: 000 zero, 001 A+B, 010 A-B

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-high; asserting it at any time, mid-instruction included, immediately forces State=Init, PC=0 and IR=0.
- Reset values: all other outputs are 0.
- Opcode map, IR[15:12]:
  - 0000 NOOP
  - 0001 STORE: D[IR[7:0]] <= RF[IR[11:8]]
  - 0010 LOAD: RF[IR[3:0]] <= D[IR[11:4]]
  - 0011 ADD: RF[IR[3:0]] <= RF[IR[11:8]] + RF[IR[7:4]]
  - 0100 SUB: RF[IR[3:0]] <= RF[IR[11:8]] - RF[IR[7:4]]
  - 0101 HALT
  - 0110-1111 are executed as NOOP.
- State codes: Init=0, Fetch=1, Decode=2, Noop=3, Load_A=4, Load_B=5, Store=6, Add=7, Sub=8, Halt=9.
- Transitions:
  - Init -> Fetch -> Decode -> (opcode-selected state)
  - Noop, Store, Add, Sub, Load_B -> Fetch
  - Load_A -> Load_B
  - Halt -> Halt, until Reset.
- Fetch: IR <= Instr_in and PC <= PC+1 at the closing edge. PC is modulo 2^PC_W: 31 -> 0, no flag.
- Outputs are Moore: a function of State plus IR fields only. Every output not listed for a state is 0.
  - Load_A: D_addr=IR[11:4]. Data memory read is synchronous, so data is valid in the next cycle.
  - Load_B: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=1.
  - Store: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1.
  - Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, RF_s=0, ALU_s0=001.
  - Sub: as Add, with ALU_s0=010.
- Instruction latency in cycles, Fetch to next Fetch exclusive:
  - NOOP, STORE, ADD, SUB: 3
  - LOAD: 4
- D_wr and RF_W_en are never asserted in Init, Fetch, Decode or Halt, and never together.
- IR and PC hold in every state except Fetch.
- No unreachable-state lockup: any illegal State encoding returns to Init on the next edge.

Decomposition:
- Shared package holds:
  - opcode constants: OP_NOOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_HALT
  - state codes: S_INIT .. S_HALT
  - ALU select codes: ALU_ZERO, ALU_ADD, ALU_SUB
  - width constants
- One sub-module is natural: pc_ir_reg, which holds the PC counter with increment/wrap and the IR load register, both under async reset.
- FSM and output decode stay in control_unit.

Test Plan:
- Reset held for one cycle, then released -> State sequence 0,1,2. PC_addr 0 -> 1 after Fetch. All enables 0 during Init.
- ROM[0]=0x21B3 (LOAD) -> states 1,2,4,5. D_addr=0x1B in Load_A and Load_B. In Load_B: RF_s=1, RF_W_en=1, RF_W_addr=3.
- ROM[1]=0x3124 (ADD) -> Add state: Ra=1, Rb=2, RF_W_addr=4, ALU_s0=001, RF_W_en=1, RF_s=0. ROM[2]=0x4124 (SUB) gives the same fields with ALU_s0=010.
- ROM[3]=0x1405 (STORE) -> Store state: D_wr=1, D_addr=0x05, RF_Ra_addr=4, RF_W_en=0.
- ROM[4]=0x5000 (HALT) -> State stays 9 for 20+ cycles with PC_addr=5 and all enables 0. Reset then returns to State 0 with PC 0.
- All-NOOP ROM run for 32 instructions -> PC wraps 31 -> 0. Opcode 0xF -> behaves as Noop (State 3). Reset asserted between clock edges during Load_A -> State=0 and PC=0 before the next edge; RF_W_en never pulses.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, FSM state codes,
// ALU select codes, widths and the Moore output decode.
package control_unit_pkg;

  localparam int PC_WIDTH    = 5;
  localparam int INSTR_WIDTH = 16;
  localparam int DADDR_WIDTH = 8;
  localparam int RADDR_WIDTH = 4;
  localparam int STATE_WIDTH = 4;
  localparam int ALU_WIDTH   = 3;

  // Opcodes carried in IR[15:12]
  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  // FSM state codes, exported on the State port
  typedef enum logic [STATE_WIDTH-1:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  // ALU operation selects
  localparam logic [ALU_WIDTH-1:0] ALU_ZERO = 3'b000;
  localparam logic [ALU_WIDTH-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALU_WIDTH-1:0] ALU_SUB  = 3'b010;

  // Bundle of every datapath control driven by the controller
  typedef struct packed {
    logic [DADDR_WIDTH-1:0] d_addr;
    logic                   d_wr;
    logic                   rf_s;
    logic [RADDR_WIDTH-1:0] rf_w_addr;
    logic                   rf_w_en;
    logic [RADDR_WIDTH-1:0] rf_ra_addr;
    logic [RADDR_WIDTH-1:0] rf_rb_addr;
    logic [ALU_WIDTH-1:0]   alu_s0;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    d_addr:     8'h00,
    d_wr:       1'b0,
    rf_s:       1'b0,
    rf_w_addr:  4'h0,
    rf_w_en:    1'b0,
    rf_ra_addr: 4'h0,
    rf_rb_addr: 4'h0,
    alu_s0:     3'b000
  };

  // Moore decode: controls for a given state and the IR operand fields [11:0].
  // Anything not named for a state stays 0; illegal codes decode to idle.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [11:0] fld);
    ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      S_LOAD_A: begin
        c.d_addr = fld[11:4];
      end
      S_LOAD_B: begin
        c.d_addr    = fld[11:4];
        c.rf_s      = 1'b1;
        c.rf_w_addr = fld[3:0];
        c.rf_w_en   = 1'b1;
      end
      S_STORE: begin
        c.d_addr     = fld[7:0];
        c.rf_ra_addr = fld[11:8];
        c.d_wr       = 1'b1;
      end
      S_ADD: begin
        c.rf_ra_addr = fld[11:8];
        c.rf_rb_addr = fld[7:4];
        c.rf_w_addr  = fld[3:0];
        c.rf_w_en    = 1'b1;
        c.alu_s0     = ALU_ADD;
      end
      S_SUB: begin
        c.rf_ra_addr = fld[11:8];
        c.rf_rb_addr = fld[7:4];
        c.rf_w_addr  = fld[3:0];
        c.rf_w_en    = 1'b1;
        c.alu_s0     = ALU_SUB;
      end
      default: begin
        c = CTRL_IDLE;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_pc_ir_reg.sv
// Program counter and instruction register. Both load only on a fetch;
// the PC wraps silently at 2^PC_W.
module pc_ir_reg
  import control_unit_pkg::*;
#(
  parameter int PC_W = PC_WIDTH,
  parameter int IW   = INSTR_WIDTH
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            load_en,
  input  logic [IW-1:0]   instr_in,
  output logic [PC_W-1:0] pc_out,
  output logic [IW-1:0]   ir_out
);

  logic [PC_W-1:0] pc_r;
  logic [IW-1:0]   ir_r;

  // Capture the instruction and advance the PC at the end of a fetch cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_r <= {PC_W{1'b0}};
      ir_r <= {IW{1'b0}};
    end else if (load_en) begin
      pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
      ir_r <= instr_in;
    end else begin
      pc_r <= pc_r;
      ir_r <= ir_r;
    end
  end

  assign pc_out = pc_r;
  assign ir_out = ir_r;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller for the 16-bit datapath: owns PC, IR and the control
// FSM, and drives every datapath select/enable/address as a Moore output.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int PC_W = PC_WIDTH,
  parameter int IW   = INSTR_WIDTH,
  parameter int DA_W = DADDR_WIDTH,
  parameter int RA_W = RADDR_WIDTH
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [IW-1:0]   Instr_in,
  output logic [PC_W-1:0] PC_addr,
  output logic [IW-1:0]   IR_out,
  output logic [3:0]      State,
  output logic [DA_W-1:0] D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [RA_W-1:0] RF_W_addr,
  output logic            RF_W_en,
  output logic [RA_W-1:0] RF_Ra_addr,
  output logic [RA_W-1:0] RF_Rb_addr,
  output logic [2:0]      ALU_s0
);

  state_t          state_r;
  state_t          state_next_s;
  ctrl_t           ctrl_r;
  logic [PC_W-1:0] pc_s;
  logic [IW-1:0]   ir_s;
  logic            fetch_s;

  assign fetch_s = (state_r == S_FETCH);

  pc_ir_reg #(
    .PC_W(PC_W),
    .IW  (IW)
  ) u_pc_ir (
    .Clk     (Clk),
    .Reset   (Reset),
    .load_en (fetch_s),
    .instr_in(Instr_in),
    .pc_out  (pc_s),
    .ir_out  (ir_s)
  );

  // State register; reset lands in Init from anywhere, mid-instruction included
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= S_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; opcodes outside the defined set run as NOOP and any
  // illegal state code falls back to Init
  always_comb begin
    state_next_s = S_INIT;
    case (state_r)
      S_INIT:   state_next_s = S_FETCH;
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: begin
        case (ir_s[15:12])
          OP_NOOP:  state_next_s = S_NOOP;
          OP_STORE: state_next_s = S_STORE;
          OP_LOAD:  state_next_s = S_LOAD_A;
          OP_ADD:   state_next_s = S_ADD;
          OP_SUB:   state_next_s = S_SUB;
          OP_HALT:  state_next_s = S_HALT;
          default:  state_next_s = S_NOOP;
        endcase
      end
      S_NOOP:   state_next_s = S_FETCH;
      S_STORE:  state_next_s = S_FETCH;
      S_ADD:    state_next_s = S_FETCH;
      S_SUB:    state_next_s = S_FETCH;
      S_LOAD_A: state_next_s = S_LOAD_B;
      S_LOAD_B: state_next_s = S_FETCH;
      S_HALT:   state_next_s = S_HALT;
      default:  state_next_s = S_INIT;
    endcase
  end

  // Control outputs are registered from the upcoming state. IR only changes
  // on the edge leaving Fetch, whose successor (Decode) drives nothing, so the
  // current IR is always the one the upcoming state will see.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ctrl_r <= CTRL_IDLE;
    end else begin
      ctrl_r <= decode_ctrl(state_next_s, ir_s[11:0]);
    end
  end

  assign PC_addr    = pc_s;
  assign IR_out     = ir_s;
  assign State      = state_r;
  assign D_addr     = ctrl_r.d_addr;
  assign D_wr       = ctrl_r.d_wr;
  assign RF_s       = ctrl_r.rf_s;
  assign RF_W_addr  = ctrl_r.rf_w_addr;
  assign RF_W_en    = ctrl_r.rf_w_en;
  assign RF_Ra_addr = ctrl_r.rf_ra_addr;
  assign RF_Rb_addr = ctrl_r.rf_rb_addr;
  assign ALU_s0     = ctrl_r.alu_s0;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed programs plus random ROM
// contents, checked cycle by cycle against an instruction-level model.
module tb_control_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Instr_in;
  logic [4:0]  PC_addr;
  logic [15:0] IR_out;
  logic [3:0]  State;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;

  logic [15:0] rom [32];
  int          checks = 0;
  int          errors = 0;
  int          mpc;   // model program counter
  logic [15:0] mir;   // model instruction register
  bit          halted;

  assign Instr_in = rom[PC_addr];

  always #5 Clk = ~Clk;

  control_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Instr_in  (Instr_in),
    .PC_addr   (PC_addr),
    .IR_out    (IR_out),
    .State     (State),
    .D_addr    (D_addr),
    .D_wr      (D_wr),
    .RF_s      (RF_s),
    .RF_W_addr (RF_W_addr),
    .RF_W_en   (RF_W_en),
    .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0    (ALU_s0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare every output against the expected cycle; PC/IR come from the model
  task automatic expect_cycle(input string tag, input int st, input int da, input int dw,
                              input int rs, input int wa, input int we, input int ra,
                              input int rb, input int alu);
    chk({tag, ".state"}, State, st);
    chk({tag, ".pc"}, PC_addr, mpc);
    chk({tag, ".ir"}, IR_out, mir);
    chk({tag, ".d_addr"}, D_addr, da);
    chk({tag, ".d_wr"}, D_wr, dw);
    chk({tag, ".rf_s"}, RF_s, rs);
    chk({tag, ".w_addr"}, RF_W_addr, wa);
    chk({tag, ".w_en"}, RF_W_en, we);
    chk({tag, ".ra"}, RF_Ra_addr, ra);
    chk({tag, ".rb"}, RF_Rb_addr, rb);
    chk({tag, ".alu"}, ALU_s0, alu);
    chk({tag, ".wr_excl"}, {31'd0, D_wr & RF_W_en}, 0);
  endtask

  task automatic expect_idle(input string tag, input int st);
    expect_cycle(tag, st, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Hold reset for one cycle; model returns to PC=0, IR=0
  task automatic apply_reset();
    Reset = 1'b1;
    mpc = 0;
    mir = 16'h0000;
    @(negedge Clk);
    expect_idle("reset", 0);
    Reset = 1'b0;
  endtask

  // Execute one instruction in the model, checking each cycle from Fetch on
  task automatic run_instr(output bit hit_halt);
    @(negedge Clk);
    expect_idle("fetch", 1);
    mir = rom[mpc];
    mpc = (mpc + 1) % 32;
    @(negedge Clk);
    expect_idle("decode", 2);
    hit_halt = 1'b0;
    case (mir[15:12])
      4'h1: begin
        @(negedge Clk);
        expect_cycle("store", 6, mir[7:0], 1, 0, 0, 0, mir[11:8], 0, 0);
      end
      4'h2: begin
        @(negedge Clk);
        expect_cycle("load_a", 4, mir[11:4], 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        expect_cycle("load_b", 5, mir[11:4], 0, 1, mir[3:0], 1, 0, 0, 0);
      end
      4'h3: begin
        @(negedge Clk);
        expect_cycle("add", 7, 0, 0, 0, mir[3:0], 1, mir[11:8], mir[7:4], 1);
      end
      4'h4: begin
        @(negedge Clk);
        expect_cycle("sub", 8, 0, 0, 0, mir[3:0], 1, mir[11:8], mir[7:4], 2);
      end
      4'h5: begin
        @(negedge Clk);
        expect_idle("halt", 9);
        hit_halt = 1'b1;
      end
      default: begin
        @(negedge Clk);
        expect_idle("noop", 3);
      end
    endcase
  endtask

  initial begin
    // Directed program: LOAD, ADD, SUB, STORE, HALT
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0] = 16'h21B3;
    rom[1] = 16'h3124;
    rom[2] = 16'h4124;
    rom[3] = 16'h1405;
    rom[4] = 16'h5000;
    apply_reset();
    halted = 1'b0;
    for (int n = 0; n < 8 && !halted; n++) run_instr(halted);
    chk("halt_reached", {31'd0, halted}, 1);
    for (int n = 0; n < 22; n++) begin
      @(negedge Clk);
      expect_idle("halt_hold", 9);
    end
    chk("halt_pc", PC_addr, 5);

    // Reset out of Halt, then an all-NOOP ROM with one 0xF opcode to wrap PC
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[7] = 16'hF123;
    apply_reset();
    chk("post_halt_reset_pc", PC_addr, 0);
    for (int n = 0; n < 32; n++) run_instr(halted);
    chk("pc_wrap", PC_addr, 0);
    run_instr(halted);
    chk("pc_after_wrap", PC_addr, 1);

    // Random ROM contents (any opcode except HALT)
    for (int i = 0; i < 32; i++) begin
      int          r;
      logic [31:0] bits;
      logic [3:0]  op;
      r = int'($urandom_range(0, 14));
      op = (r < 5) ? 4'(r) : 4'(r + 1);
      bits = $urandom;
      rom[i] = {op, bits[11:0]};
    end
    apply_reset();
    for (int n = 0; n < 48; n++) run_instr(halted);

    // Reset asserted between edges while in Load_A
    rom[0] = 16'h21B3;
    apply_reset();
    @(negedge Clk);
    expect_idle("mid_fetch", 1);
    mir = rom[mpc];
    mpc = (mpc + 1) % 32;
    @(negedge Clk);
    expect_idle("mid_decode", 2);
    @(negedge Clk);
    expect_cycle("mid_load_a", 4, 8'h1B, 0, 0, 0, 0, 0, 0, 0);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_state", State, 0);
    chk("async_pc", PC_addr, 0);
    chk("async_ir", IR_out, 0);
    chk("async_w_en", RF_W_en, 0);
    chk("async_d_addr", D_addr, 0);
    @(negedge Clk);
    chk("async_hold_state", State, 0);
    chk("async_hold_w_en", RF_W_en, 0);
    Reset = 1'b0;
    mpc = 0;
    mir = 16'h0000;
    run_instr(halted);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
